// File: rtl/otter_stim_pkg.sv
// otter_stim_pkg: state encoding and default parameters shared by the OTTER stimulus sequencer
package otter_stim_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HOLD_RST = 3'd1,
      APPLY    = 3'd2,
      WAIT     = 3'd3,
      DONE     = 3'd4
   } stim_state_t;
   localparam int DEF_NUM_SW     = 16;
   localparam int DEF_NUM_LED    = 16;
   localparam int DEF_NUM_STEPS  = 4;
   localparam int DEF_RST_CYCLES = 60;
   localparam int DEF_MATCH_HOLD = 8;
   localparam int DEF_TIMEOUT    = 100000;
endpackage

// File: rtl/otter_stim_match_filter.sv
// otter_stim_match_filter: masked LED compare with stability and timeout counting for one step
module otter_stim_match_filter import otter_stim_pkg::*; #(
   parameter int NUM_LED    = DEF_NUM_LED,
   parameter int MATCH_HOLD = DEF_MATCH_HOLD,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               en,
   input  logic [NUM_LED-1:0] leds,
   input  logic [NUM_LED-1:0] exp_leds,
   input  logic [NUM_LED-1:0] mask,
   output logic               matched,
   output logic               timed_out
);
   localparam int HW = $clog2(MATCH_HOLD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [HW-1:0] hold_cnt;
   logic [TW-1:0] tmo_cnt;
   logic          hit;
   assign hit = ((leds ^ exp_leds) & mask) == '0;
   // both flags fire on the cycle their count reaches the limit, not one later
   assign matched   = en && hit && hold_cnt == HW'(MATCH_HOLD - 1);
   assign timed_out = en && tmo_cnt == TW'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         hold_cnt <= '0;
         tmo_cnt  <= '0;
      end else if (en) begin
         hold_cnt <= hit ? hold_cnt + 1'b1 : '0;
         tmo_cnt  <= tmo_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/otter_stim_sequencer.sv
// otter_stim_sequencer: resets the OTTER wrapper, applies switch patterns and checks LED responses
module otter_stim_sequencer import otter_stim_pkg::*; #(
   parameter int NUM_SW     = DEF_NUM_SW,
   parameter int NUM_LED    = DEF_NUM_LED,
   parameter int NUM_STEPS  = DEF_NUM_STEPS,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   parameter int MATCH_HOLD = DEF_MATCH_HOLD,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [NUM_STEPS*NUM_SW-1:0]     sw_patterns,
   input  logic [NUM_STEPS*NUM_LED-1:0]    led_expect,
   input  logic [NUM_LED-1:0]              led_mask,
   input  logic [NUM_LED-1:0]              leds,
   output logic                            dut_rst,
   output logic [NUM_SW-1:0]               switches,
   output logic [$clog2(NUM_STEPS):0]      step_idx,
   output logic                            busy,
   output logic                            done,
   output logic                            pass
);
   localparam int IW = $clog2(NUM_STEPS) + 1;
   localparam int RW = $clog2(RST_CYCLES + 1);
   stim_state_t       state;
   logic [RW-1:0]     rst_cnt;
   logic [NUM_SW-1:0] pattern;
   logic [NUM_LED-1:0] exp_leds;
   logic              matched;
   logic              timed_out;
   assign pattern  = sw_patterns[step_idx*NUM_SW +: NUM_SW];
   assign exp_leds = led_expect[step_idx*NUM_LED +: NUM_LED];
   assign dut_rst  = state == IDLE || state == HOLD_RST;
   assign busy     = state == HOLD_RST || state == APPLY || state == WAIT;
   assign done     = state == DONE;
   otter_stim_match_filter #(
      .NUM_LED    (NUM_LED),
      .MATCH_HOLD (MATCH_HOLD),
      .TIMEOUT    (TIMEOUT)
   ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .clear     (state == APPLY),
      .en        (state == WAIT),
      .leds      (leds),
      .exp_leds  (exp_leds),
      .mask      (led_mask),
      .matched   (matched),
      .timed_out (timed_out)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rst_cnt  <= '0;
         switches <= '0;
         step_idx <= '0;
         pass     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state    <= HOLD_RST;
               rst_cnt  <= '0;
               switches <= '0;
               step_idx <= '0;
               pass     <= 1'b0;
            end
            HOLD_RST: begin
               switches <= '0;
               rst_cnt  <= rst_cnt + 1'b1;
               if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                  rst_cnt <= '0;
                  state   <= APPLY;
               end
            end
            APPLY: begin
               switches <= pattern;
               state    <= WAIT;
            end
            WAIT: if (matched) begin
               // a step that stabilises on its timeout cycle still counts as passed
               if (step_idx == IW'(NUM_STEPS - 1)) begin
                  state    <= DONE;
                  pass     <= 1'b1;
                  step_idx <= IW'(NUM_STEPS);
               end else begin
                  state    <= APPLY;
                  step_idx <= step_idx + 1'b1;
               end
            end else if (timed_out) begin
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_otter_stim_sequencer.sv
// tb_otter_stim_sequencer: randomized schedules checked against a window-based outcome model
module tb_otter_stim_sequencer;
   localparam int NS = 2;
   localparam int R  = 4;
   localparam int MH = 8;
   localparam int TO = 50;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   sw_patterns;
   logic [31:0]   led_expect;
   logic [15:0]   mask = 16'hFFFF;
   logic [15:0]   leds;
   logic [15:0]   leds_drv = '0;
   logic          dut_rst;
   logic [15:0]   switches;
   logic [1:0]    step_idx;
   logic          busy;
   logic          done;
   logic          pass;
   logic [15:0]   pats [NS];
   logic [15:0]   exps [NS];
   logic [15:0]   pipe [3];
   bit            echo = 1'b0;
   bit            mb [NS][TO+1];
   int            pk [NS];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   // wrapper stand-in for the echo test: LEDS follow SWITCHES three cycles late
   always @(posedge clk) begin
      pipe[0] <= switches;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end
   assign leds        = echo ? pipe[2] : leds_drv;
   assign sw_patterns = {pats[1], pats[0]};
   assign led_expect  = {exps[1], exps[0]};

   otter_stim_sequencer #(
      .NUM_SW(16), .NUM_LED(16), .NUM_STEPS(NS),
      .RST_CYCLES(R), .MATCH_HOLD(MH), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .sw_patterns(sw_patterns), .led_expect(led_expect), .led_mask(mask),
      .leds(leds), .dut_rst(dut_rst), .switches(switches),
      .step_idx(step_idx), .busy(busy), .done(done), .pass(pass)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic logic [31:0] st();
      return {26'd0, busy, done, dut_rst, pass, step_idx};
   endfunction

   function automatic logic [31:0] w(input bit b, input bit d, input bit r, input bit p, input int i);
      logic [1:0] ix = 2'(i);
      return {26'd0, b, d, r, p, ix};
   endfunction

   // a step passes at the first WAIT cycle ending a full window of MH matches
   function automatic int first_pass(input int s);
      for (int k = MH; k <= TO; k++) begin
         bit all = 1'b1;
         for (int j = k - MH + 1; j <= k; j++) if (!mb[s][j]) all = 1'b0;
         if (all) return k;
      end
      return 0;
   endfunction

   task automatic fill(input int s, input int mode);
      int c = $urandom_range(20, 1);
      for (int k = 1; k <= TO; k++)
         mb[s][k] = mode == 0 ? k >= c :
                    mode == 1 ? k != 6 :
                    mode == 2 ? 1'b0 :
                    mode == 3 ? k >= TO - MH + 1 :
                    mode == 4 ? k >= TO - MH + 2 :
                    ($urandom % 100) < 85;
   endtask

   function automatic logic [15:0] gen_leds(input logic [15:0] e, input logic [15:0] m, input bit hit);
      logic [15:0] v = e ^ (16'($urandom) & ~m);
      int idx;
      if (!hit) begin
         do idx = $urandom_range(15, 0); while (!m[idx]);
         v[idx] = ~v[idx];
      end
      return v;
   endfunction

   task automatic run_sched(input int m0, input int m1, input logic [15:0] mk, input bit inject);
      bit ok;
      int last;
      for (int s = 0; s < NS; s++) begin
         pats[s] = 16'($urandom);
         exps[s] = 16'($urandom);
         fill(s, s == 0 ? m0 : m1);
         pk[s] = first_pass(s);
      end
      case ($urandom_range(2, 0))
         0: mask = 16'hFFFF;
         1: mask = 16'h00FF;
         default: mask = 16'($urandom) | 16'h0001;
      endcase
      if (mk != 0) mask = mk;
      ok   = pk[0] != 0 && pk[1] != 0;
      last = pk[0] == 0 ? 0 : NS - 1;
      @(negedge clk);
      start = 1'b1;
      leds_drv = 16'($urandom);
      for (int i = 1; i <= R; i++) begin
         @(negedge clk);
         start = 1'b0;
         chk("hold_state", st(), w(1, 0, 1, 0, 0));
         if (i == R) chk("hold_sw", switches, 0);
      end
      for (int s = 0; s <= last; s++) begin
         @(negedge clk);
         chk("apply_state", st(), w(1, 0, 0, 0, s));
         leds_drv = 16'($urandom);
         for (int k = 1; k <= (pk[s] != 0 ? pk[s] : TO); k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("wait_state", st(), w(1, 0, 0, 0, s));
            chk("wait_sw", switches, pats[s]);
            leds_drv = gen_leds(exps[s], mask, mb[s][k]);
            start = inject && k == 2;
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("final_state", st(), w(0, 1, 0, ok, ok ? NS : last));
      chk("final_sw", switches, pats[last]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      pats[0] = 16'h1234; pats[1] = 16'h00A5;
      exps[0] = 16'h1234; exps[1] = 16'h00A5;
      repeat (3) @(negedge clk);
      chk("rst_state", st(), w(0, 0, 1, 0, 0));
      chk("rst_sw", switches, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_state", st(), w(0, 0, 1, 0, 0));
      begin
         int n = 0, hi = 0;
         echo = 1'b1;
         mask = 16'hFFFF;
         start = 1'b1;
         while (!done && n < 400) begin
            @(negedge clk);
            start = 1'b0;
            if (dut_rst) hi++;
            n++;
         end
         chk("echo_rst_cycles", hi, R);
         chk("echo_final", st(), w(0, 1, 0, 1, NS));
         chk("echo_sw", switches, 16'h00A5);
         echo = 1'b0;
      end
      run_sched(0, 0, 16'hFFFF, 0);
      run_sched(0, 2, 16'hFFFF, 0);
      run_sched(1, 1, 16'hFFFF, 0);
      run_sched(0, 0, 16'h00FF, 0);
      run_sched(3, 3, 16'hFFFF, 0);
      run_sched(0, 4, 16'hFFFF, 0);
      run_sched(0, 0, 16'hFFFF, 1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_abort", st(), w(1, 0, 0, 0, 0));
      rst = 1'b1;
      @(negedge clk);
      chk("abort_state", st(), w(0, 0, 1, 0, 0));
      chk("abort_sw", switches, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle", st(), w(0, 0, 1, 0, 0));
      run_sched(1, 0, 16'h00FF, 0);
      repeat (30) run_sched($urandom_range(5, 0), $urandom_range(5, 0), 16'h0, 1'($urandom_range(1, 0)));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
